uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_tx_queue.sv | 105 ++++++++++
 tb/tb_uart_tx_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: CPU-side pushes, a four-state drain engine
// hands one byte at a time to the transmitter and waits out the whole frame.
module uart_tx_queue #(
    parameter int DEPTH = 8
) (
    input  logic       clk_uart,
    input  logic       rst,
    input  logic [7:0] wr_d,
    input  logic       wr_en,
    output logic       full,
    output logic [4:0] count,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic [7:0] tx_d,
    output logic       tx_en,
    input  logic       tx_rdy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_d_q, tx_d_d;
    logic          push, pop;

    assign full     = (count_q == 5'(DEPTH));
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_d     = tx_d_q;
    assign tx_en    = tx_en_q;

    always_comb begin
        // Pop looks at the registered count, so a byte pushed this cycle waits a cycle.
        push       = wr_en && !full;
        pop        = (state_q == IDLE) && (count_q != 5'd0) && tx_rdy;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_d_d     = tx_d_q;
        tx_en_d    = pop;
        overflow_d = overflow_q;
        state_d    = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            tx_d_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        // A dropped write outranks a clear in the same cycle.
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        case (state_q)
            IDLE:      if (pop) state_d = ISSUE;
            ISSUE:     state_d = WAIT_LOW;
            WAIT_LOW:  if (!tx_rdy) state_d = WAIT_HIGH;
            WAIT_HIGH: if (tx_rdy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 5'd0;
            overflow_q <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_d_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_en_q    <= tx_en_d;
            tx_d_q     <= tx_d_d;
        end
    end

    // Storage array kept free of reset so it maps onto RAM.
    always_ff @(posedge clk_uart) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= wr_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomised and directed bench for uart_tx_queue against a queue-level model
// and a simple UART transmitter model that drives tx_rdy.
module tb_uart_tx_queue;
    localparam int DEPTH  = 8;
    localparam int FRAME  = 20;

    logic       clk_uart = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] wr_d     = 8'h00;
    logic       wr_en    = 1'b0;
    logic       ovf_clr  = 1'b0;
    logic       tx_rdy   = 1'b1;
    logic       full, overflow, tx_en;
    logic [4:0] count;
    logic [7:0] tx_d;

    always #5 clk_uart = ~clk_uart;

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk_uart (clk_uart),
        .rst      (rst),
        .wr_d     (wr_d),
        .wr_en    (wr_en),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_d     (tx_d),
        .tx_en    (tx_en),
        .tx_rdy   (tx_rdy)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Queue-level model: FIFO contents, hold byte, sticky flag, engine availability.
    byte unsigned mq[$];
    byte unsigned exp_tx[$];
    byte unsigned rx_log[$];
    bit [7:0]     m_hold   = 8'h00;
    bit           m_ovf    = 1'b0;
    bit           m_txen   = 1'b0;
    bit           m_idle   = 1'b1;
    bit           m_skip   = 1'b0;
    bit           m_low    = 1'b0;

    // Transmitter model state.
    bit           uart_auto  = 1'b1;
    bit           busy       = 1'b0;
    int           frame_left = 0;
    bit [7:0]     cap        = 8'h00;
    bit           frame_rst  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        bit       rdy_s, txen_s, rst_s, was_full, can_issue;
        bit [7:0] txd_s;
        rdy_s  = tx_rdy;
        txen_s = tx_en;
        txd_s  = tx_d;
        rst_s  = rst;

        if (rst) begin
            mq.delete();
            m_hold = 8'h00; m_ovf = 1'b0; m_txen = 1'b0;
            m_idle = 1'b1;  m_skip = 1'b0; m_low = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            can_issue = m_idle && (mq.size() != 0) && rdy_s;
            if (can_issue) begin
                m_hold = mq.pop_front();
                exp_tx.push_back(m_hold);
                m_txen = 1'b1; m_idle = 1'b0; m_skip = 1'b1; m_low = 1'b0;
            end else begin
                m_txen = 1'b0;
                // After an issue: ignore one cycle, then need a low sample, then a high one.
                if (!m_idle) begin
                    if (m_skip) m_skip = 1'b0;
                    else if (!m_low) begin
                        if (!rdy_s) m_low = 1'b1;
                    end else if (rdy_s) m_idle = 1'b1;
                end
            end
            if (wr_en) begin
                if (was_full) m_ovf = 1'b1;
                else mq.push_back(wr_d);
            end
            if (!(wr_en && was_full) && ovf_clr) m_ovf = 1'b0;
        end

        @(posedge clk_uart);
        @(negedge clk_uart);

        if (uart_auto) begin
            if (!busy) begin
                if (txen_s && rdy_s) begin
                    busy = 1'b1; cap = txd_s; frame_left = FRAME;
                    frame_rst = rst_s; tx_rdy = 1'b0;
                end
            end else begin
                if (rst_s) frame_rst = 1'b1;
                frame_left--;
                if (frame_left == 0) begin
                    busy = 1'b0; tx_rdy = 1'b1;
                    rx_log.push_back(cap);
                    if (exp_tx.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL uart_frame: got 0x%0h, expected no frame", cap);
                    end else begin
                        chk("uart_frame", cap, exp_tx.pop_front());
                    end
                end
            end
            if (busy && !frame_rst && !rst_s) chk("tx_d_stable", tx_d, cap);
        end

        chk("count",    count,    mq.size());
        chk("full",     full,     (mq.size() == DEPTH));
        chk("overflow", overflow, m_ovf);
        chk("tx_en",    tx_en,    m_txen);
        chk("tx_d",     tx_d,     m_hold);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !m_idle || m_txen || mq.size() != 0) && n < 2000) begin
            step();
            n++;
        end
        vectors++;
        if (n >= 2000) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d cycles, expected < 2000", n);
        end
    endtask

    initial begin
        int k;
        int guard;
        int rate;

        repeat (3) step();
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_txen", tx_en, 0);
        chk("rst_txd", tx_d, 8'h00);
        rst = 1'b0;
        step();

        // Single byte and latency.
        rx_log.delete();
        wr_en = 1'b1; wr_d = 8'hA5; step(); wr_en = 1'b0;
        chk("lat1_txen", tx_en, 0);
        chk("lat1_count", count, 1);
        step();
        chk("lat2_txen", tx_en, 1);
        chk("lat2_txd", tx_d, 8'hA5);
        chk("lat2_count", count, 0);
        step();
        chk("lat3_txen", tx_en, 0);
        wait_idle();
        chk("single_rx_n", rx_log.size(), 1);
        chk("single_rx", rx_log[0], 8'hA5);

        // Burst in order.
        rx_log.delete();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_d = 8'(i); step();
        end
        wr_en = 1'b0;
        wait_idle();
        chk("burst_n", rx_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("burst_byte", rx_log[i], i + 1);

        // Overflow with the transmitter held busy.
        uart_auto = 1'b0; tx_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_d = 8'(8'h10 + i); step();
        end
        wr_en = 1'b0;
        chk("ovf_count", count, 8);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        wr_en = 1'b1; ovf_clr = 1'b1; wr_d = 8'hEE; step();
        wr_en = 1'b0; ovf_clr = 1'b0;
        chk("setclr_ovf", overflow, 1);
        chk("setclr_count", count, 8);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        rx_log.delete();
        uart_auto = 1'b1; tx_rdy = 1'b1;
        wait_idle();
        chk("ovf_rx_n", rx_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("ovf_rx_byte", rx_log[i], 8'h10 + i);

        // Sustained writes while draining; pointers wrap.
        rx_log.delete();
        k = 0; guard = 0;
        while (k < 20 && guard < 3000) begin
            if (mq.size() < DEPTH) begin
                wr_en = 1'b1; wr_d = 8'(8'h40 + k); k++;
            end else begin
                wr_en = 1'b0;
            end
            step();
            guard++;
        end
        wr_en = 1'b0;
        wait_idle();
        chk("wrap_n", rx_log.size(), 20);
        for (int i = 0; i < 20; i++) chk("wrap_byte", rx_log[i], 8'h40 + i);

        // Reset while waiting for the end of a frame.
        rx_log.delete();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_d = 8'(8'h60 + i); step();
        end
        wr_en = 1'b0;
        guard = 0;
        while (!(!m_idle && m_low) && guard < 200) begin
            step(); guard++;
        end
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_txen", tx_en, 0);
        chk("mid_rst_txd", tx_d, 8'h00);
        wr_en = 1'b1; wr_d = 8'h3C; step(); wr_en = 1'b0;
        wait_idle();
        chk("mid_rst_rx_n", rx_log.size(), 2);
        chk("mid_rst_rx0", rx_log[0], 8'h60);
        chk("mid_rst_rx1", rx_log[1], 8'h3C);

        // Random traffic at varying write rates.
        rate = 5;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) rate = (c % 1500 == 0) ? 60 : ((c % 1000 == 0) ? 2 : 8);
            wr_en   = ($urandom_range(0, 99) < rate);
            wr_d    = 8'($urandom);
            ovf_clr = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 599) == 0);
            step();
        end
        wr_en = 1'b0; ovf_clr = 1'b0; rst = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
